program_loader: RTL and testbench
=================================

# program_loader

Parametrised successor to the byte loader: receives a program as a stream of parallel words qualified by a `newData` strobe and writes each word, exactly once, into consecutive program-RAM addresses starting at 0. Adds a start/busy/done handshake, terminator-word detection, overflow protection without address wrap, and a written-length count. Sits between the host receive front-end (UART/parallel port) and the processor's program RAM write port.

## Interface
- `DATA_W`, 8, width of program words and RAM data.
- `ADDR_W`, 9, RAM address width; depth = 2**ADDR_W.
- `END_WORD`, 0, terminator value; when written, loading completes.
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  level; begins a load from address 0 when not busy.
- `dataIn`  in  DATA_W  incoming program word, valid while `newData` high.
- `newData`  in  1  word strobe; one word per low-to-high transition.
- `write_rq`  out  1  RAM write enable, one-cycle pulse per word.
- `addrOut`  out  ADDR_W  RAM write address.
- `dataOut`  out  DATA_W  RAM write data.
- `busy`  out  1  high in LOAD.
- `done`  out  1  high in DONE (terminator written).
- `overflow`  out  1  high in ERROR (RAM full, no terminator).
- `length`  out  ADDR_W+1  number of words written this load, terminator included.

## Operation
- States: IDLE, LOAD, DONE, ERROR. Reset → IDLE; every output 0; edge-tracking register 0.
- IDLE/DONE/ERROR + `start`=1 → LOAD; `addrOut`, `length` (and checksum) cleared to 0.
- LOAD ignores `start`. DONE/ERROR hold outputs until `start` or reset.
- Edge detect: `rise = newData & ~newData_q`; `newData_q` updates every cycle in every state. `rise` outside LOAD is discarded; `rise` in the same cycle as the IDLE→LOAD `start` is discarded.
- In LOAD on `rise`: `dataOut`←`dataIn`, `write_rq`←1, `addrOut` unchanged, `length`←`length`+1.
- Cycle after a write: `write_rq`←0, then:
  - `dataOut`==`END_WORD` → DONE, `addrOut` unchanged.
  - else `addrOut`==2**ADDR_W−1 → ERROR, `addrOut` stays at max (no wrap).
  - else `addrOut`←`addrOut`+1, stay LOAD.
- `newData` held high writes one word only.
- Reset mid-load: immediate return to IDLE, `write_rq` drops asynchronously; partial RAM content is not cleaned.

## Timing
- Edge sampled at clock k → `write_rq`=1 with address A and data during cycle k..k+1 → address A+1 visible after edge k+1.
- Write latency: 1 cycle from sampled strobe to `write_rq`.
- Minimum strobe period: 2 cycles (high ≥1 sample, low ≥1 sample); faster toggling drops words.
- `done`/`overflow`/`busy` change at edge k+1 of the final write.
- `length` valid from edge k; maximum value 2**ADDR_W.

## Configuration
- `PROGRAM_LOADER_CHECKSUM_EN` defined: extra output `checksum` out DATA_W, modulo-2**DATA_W sum of every written word (terminator included), updated on the same edge as `write_rq` rises, cleared by reset and by load start.
- Not defined: port and adder absent; all other behaviour identical.

## Structure
- Shared package: state enum (IDLE, LOAD, DONE, ERROR) and default `END_WORD`.
- One sub-module natural: `strobe_edge_detect` (register plus rise output), reusable by other front-end blocks.

## Test plan
- Reset with `start`=1, `newData`=1 → all outputs 0, state IDLE; after release, no write until `start`.
- `start`, then words 0x2B,0x2B,0x2E,0x00 at 4-cycle spacing → writes at addr 0..3, `done`=1, `length`=4, `addrOut`=3; checksum (macro on) = 0x84.
- `newData` held high 10 cycles with 0x3E in LOAD → exactly one `write_rq` pulse, `length`=1.
- ADDR_W=2, five non-terminator words → writes addr 0..3, `overflow`=1, `addrOut`=3, `length`=4, fifth word ignored.
- `newData` rise in same cycle as `start` from IDLE → no write; next rise writes at addr 0.
- Reset asserted mid-write (during `write_rq`) → `write_rq` low same cycle, IDLE; new `start` restarts at addr 0, `length`=0.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared types and defaults for the program loader and its front-end helpers.
package program_loader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DONE  = 2'd2,
      ERROR = 2'd3
   } state_t;

   localparam int unsigned END_WORD_DEFAULT = 0;

endpackage

// File: rtl/program_loader_strobe_edge_detect.sv
// Rising-edge detector for a level strobe: one registered sample plus a combinational rise flag.
module strobe_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic strobe,
   output logic rise_c
);

   logic strobe_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) strobe_q <= 1'b0;
      else       strobe_q <= strobe;
   end

   assign rise_c = strobe & ~strobe_q;

endmodule

// File: rtl/program_loader.sv
// Streams strobed words into program RAM from address 0 with terminator/overflow detection.
// Optional running checksum output enabled by PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
   import program_loader_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 9,
   parameter logic [DATA_W-1:0] END_WORD = DATA_W'(END_WORD_DEFAULT)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] dataIn,
   input  logic              newData,
   output logic              write_rq,
   output logic [ADDR_W-1:0] addrOut,
   output logic [DATA_W-1:0] dataOut,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic [ADDR_W:0]   length
`ifdef PROGRAM_LOADER_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0] checksum
`endif
);

   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

   state_t            state, state_next;
   logic              rise;
   logic              write_rq_n;
   logic [ADDR_W-1:0] addr_n;
   logic [DATA_W-1:0] data_n;
   logic [ADDR_W:0]   length_n;

   strobe_edge_detect u_edge (
      .clk    (clk),
      .reset  (reset),
      .strobe (newData),
      .rise_c (rise)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Completion is decided in the cycle after a write, from the word just written.
   always_comb begin
      state_next = state;
      case (state)
         LOAD: begin
            if (write_rq) begin
               if (dataOut == END_WORD)     state_next = DONE;
               else if (addrOut == ADDR_MAX) state_next = ERROR;
            end
         end
         IDLE, DONE, ERROR: begin
            if (start) state_next = LOAD;
         end
         default: state_next = IDLE;
      endcase
   end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [DATA_W-1:0] checksum_n;
`endif

   always_comb begin
      write_rq_n = 1'b0;
      addr_n     = addrOut;
      data_n     = dataOut;
      length_n   = length;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      checksum_n = checksum;
`endif
      if (state == LOAD) begin
         if (write_rq) begin
            if (dataOut != END_WORD && addrOut != ADDR_MAX)
               addr_n = ADDR_W'(addrOut + ADDR_W'(1));
         end else if (rise) begin
            write_rq_n = 1'b1;
            data_n     = dataIn;
            length_n   = (ADDR_W+1)'(length + (ADDR_W+1)'(1));
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            checksum_n = DATA_W'(checksum + dataIn);
`endif
         end
      end else if (start) begin
         addr_n   = '0;
         length_n = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         checksum_n = '0;
`endif
      end
   end

   // Status flags track the state being entered so they change on the same edge as the state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         write_rq <= 1'b0;
         addrOut  <= '0;
         dataOut  <= '0;
         length   <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         overflow <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         checksum <= '0;
`endif
      end else begin
         write_rq <= write_rq_n;
         addrOut  <= addr_n;
         dataOut  <= data_n;
         length   <= length_n;
         busy     <= (state_next == LOAD);
         done     <= (state_next == DONE);
         overflow <= (state_next == ERROR);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         checksum <= checksum_n;
`endif
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Randomised and directed bench for program_loader at two RAM depths against a word-count model.
module tb_program_loader;

   logic       clk = 1'b0;
   logic       reset, start, newData;
   logic [7:0] dataIn;

   logic       wr0, b0, dn0, ov0;
   logic [8:0] a0;
   logic [7:0] d0;
   logic [9:0] len0;
   logic       wr1, b1, dn1, ov1;
   logic [1:0] a1;
   logic [7:0] d1;
   logic [2:0] len1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [7:0] cs0, cs1;
`endif

   int asserts = 0;
   int fails   = 0;

   program_loader #(.DATA_W(8), .ADDR_W(9), .END_WORD(8'h00)) dut (
      .clk(clk), .reset(reset), .start(start), .dataIn(dataIn), .newData(newData),
      .write_rq(wr0), .addrOut(a0), .dataOut(d0), .busy(b0), .done(dn0),
      .overflow(ov0), .length(len0)
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      , .checksum(cs0)
`endif
   );

   program_loader #(.DATA_W(8), .ADDR_W(2), .END_WORD(8'h00)) dut_s (
      .clk(clk), .reset(reset), .start(start), .dataIn(dataIn), .newData(newData),
      .write_rq(wr1), .addrOut(a1), .dataOut(d1), .busy(b1), .done(dn1),
      .overflow(ov1), .length(len1)
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      , .checksum(cs1)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      asserts++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a load is a count of words accepted; the address is derived from that count.
   bit         ld   [2];
   bit         pd   [2];
   bit         mdn  [2];
   bit         mov  [2];
   int         cnt  [2];
   int         depth[2];
   logic [7:0] last [2];
   logic [7:0] sm   [2];
   bit         nd_prev;
   bit         m_rise;

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         ld[i] = 0; pd[i] = 0; mdn[i] = 0; mov[i] = 0;
         cnt[i] = 0; last[i] = 8'h00; sm[i] = 8'h00;
      end
      nd_prev = 0;
   endtask

   task automatic model_step(input int i);
      if (!ld[i]) begin
         if (start) begin
            ld[i] = 1; pd[i] = 0; mdn[i] = 0; mov[i] = 0; cnt[i] = 0; sm[i] = 8'h00;
         end
      end else if (pd[i]) begin
         pd[i] = 0;
         if (last[i] == 8'h00) begin ld[i] = 0; mdn[i] = 1; end
         else if (cnt[i] == depth[i]) begin ld[i] = 0; mov[i] = 1; end
      end else if (m_rise) begin
         last[i] = dataIn;
         sm[i]   = 8'(sm[i] + dataIn);
         cnt[i]  = cnt[i] + 1;
         pd[i]   = 1;
      end
   endtask

   function automatic int exp_addr(input int i);
      return (pd[i] || mdn[i] || mov[i]) ? cnt[i] - 1 : cnt[i];
   endfunction

   initial begin
      depth[0] = 512;
      depth[1] = 4;
      model_reset();
   end

   always @(posedge clk) begin
      if (reset) begin
         model_reset();
      end else begin
         m_rise = newData && !nd_prev;
         model_step(0);
         model_step(1);
         nd_prev = newData;
      end
      #1;
      check("wr0", 32'(wr0), 32'(pd[0]));
      check("addr0", 32'(a0), 32'(exp_addr(0)));
      check("data0", 32'(d0), 32'(last[0]));
      check("busy0", 32'(b0), 32'(ld[0]));
      check("done0", 32'(dn0), 32'(mdn[0]));
      check("ovf0", 32'(ov0), 32'(mov[0]));
      check("len0", 32'(len0), 32'(cnt[0]));
      check("wr1", 32'(wr1), 32'(pd[1]));
      check("addr1", 32'(a1), 32'(exp_addr(1)));
      check("data1", 32'(d1), 32'(last[1]));
      check("busy1", 32'(b1), 32'(ld[1]));
      check("done1", 32'(dn1), 32'(mdn[1]));
      check("ovf1", 32'(ov1), 32'(mov[1]));
      check("len1", 32'(len1), 32'(cnt[1]));
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      check("cs0", 32'(cs0), 32'(sm[0]));
      check("cs1", 32'(cs1), 32'(sm[1]));
`endif
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic send(input logic [7:0] w);
      dataIn = w; newData = 1'b1;
      tick(2);
      newData = 1'b0;
      tick(2);
   endtask

   int pulses;

   initial begin
      reset = 1'b1; start = 1'b1; newData = 1'b1; dataIn = 8'h55;
      tick(3);
      check("rst_wr", 32'(wr0), 32'h0);
      check("rst_addr", 32'(a0), 32'h0);
      check("rst_len", 32'(len0), 32'h0);
      check("rst_busy", 32'(b0), 32'h0);
      reset = 1'b0; start = 1'b0;
      tick(5);
      check("idle_len", 32'(len0), 32'h0);
      check("idle_busy", 32'(b0), 32'h0);
      newData = 1'b0;
      tick(2);

      // Short program ending in the terminator.
      pulse_start();
      send(8'h2B); send(8'h2B); send(8'h2E); send(8'h00);
      check("prog_done", 32'(dn0), 32'h1);
      check("prog_len", 32'(len0), 32'h4);
      check("prog_addr", 32'(a0), 32'h3);
      check("prog_busy", 32'(b0), 32'h0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      check("prog_cs", 32'(cs0), 32'h84);
`endif

      // Strobe held high yields a single write.
      pulse_start();
      dataIn = 8'h3E; newData = 1'b1;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         if (wr0) pulses++;
      end
      newData = 1'b0;
      tick(2);
      check("hold_pulses", 32'(pulses), 32'h1);
      check("hold_len", 32'(len0), 32'h1);
      send(8'h00);

      // Five non-terminator words overrun the 4-entry instance.
      pulse_start();
      send(8'h11); send(8'h12); send(8'h13); send(8'h14); send(8'h15);
      check("ovf_flag", 32'(ov1), 32'h1);
      check("ovf_addr", 32'(a1), 32'h3);
      check("ovf_len", 32'(len1), 32'h4);
      check("ovf_data", 32'(d1), 32'h14);
      check("big_len", 32'(len0), 32'h5);
      check("big_busy", 32'(b0), 32'h1);
      send(8'h00);

      // Strobe rising together with start from IDLE is dropped.
      reset = 1'b1; tick(2); reset = 1'b0; tick(1);
      start = 1'b1; newData = 1'b1; dataIn = 8'h77;
      tick(1);
      start = 1'b0;
      tick(1);
      newData = 1'b0;
      tick(2);
      check("same_len", 32'(len0), 32'h0);
      check("same_busy", 32'(b0), 32'h1);
      dataIn = 8'h42; newData = 1'b1;
      tick(1);
      check("same_wr", 32'(wr0), 32'h1);
      check("same_waddr", 32'(a0), 32'h0);
      check("same_wdata", 32'(d0), 32'h42);
      newData = 1'b0;
      tick(3);

      // Reset during an active write.
      dataIn = 8'h5A; newData = 1'b1;
      tick(1);
      check("pre_rst_wr", 32'(wr0), 32'h1);
      reset = 1'b1;
      #1;
      check("async_wr", 32'(wr0), 32'h0);
      check("async_busy", 32'(b0), 32'h0);
      tick(2);
      reset = 1'b0; newData = 1'b0;
      tick(1);
      pulse_start();
      check("restart_addr", 32'(a0), 32'h0);
      check("restart_len", 32'(len0), 32'h0);
      check("restart_busy", 32'(b0), 32'h1);

      // Random traffic against the model.
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 599) == 0) begin
            reset = 1'b1;
            tick(2);
            reset = 1'b0;
         end
         newData = 1'($urandom_range(0, 1));
         dataIn  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         start   = ($urandom_range(0, 15) == 0);
         tick(1);
      end
      start = 1'b0; newData = 1'b0;
      tick(3);

      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule
